// File: rtl/alu_mult_sequencer_pkg.sv
// Shared definitions for the EX-stage multiply sequencer: word width,
// the processor status flags and the sequencer state encoding.
package GENERAL_DEFS;

  localparam int WORD = 32;

  // Processor condition flags: negative, zero, carry, overflow.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } status_register;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/alu_mult_sequencer_radix_step.sv
// One RUN cycle of the iterative multiplier: BITS_PER_CYCLE shift-add steps
// applied back to back on the accumulator, multiplicand and multiplier.
module mult_radix_step #(
  parameter int WORD           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WORD-1:0] acc_i,
  input  logic [WORD-1:0] mcand_i,
  input  logic [WORD-1:0] mplier_i,
  output logic [WORD-1:0] acc_o,
  output logic [WORD-1:0] mcand_o,
  output logic [WORD-1:0] mplier_o
);

  // Chain the shift-add steps for one cycle.
  always_comb begin
    // NOTE: blocking assignments are intentional here: each loop iteration
    // must see the result of the previous one within the same cycle.
    acc_o    = acc_i;
    mcand_o  = mcand_i;
    mplier_o = mplier_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_o[0]) acc_o = acc_o + mcand_o;
      mcand_o  = mcand_o << 1;
      mplier_o = mplier_o >> 1;
    end
  end

endmodule

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle multiply controller for the EX stage. Accepts a request, runs
// shift-add iterations while stalling the pipeline, then presents the low
// word of the product with destination register and N/Z flags for one cycle.
module alu_mult_sequencer
  import GENERAL_DEFS::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter bit EARLY_TERM     = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [WORD-1:0] op_a_i,
  input  logic [WORD-1:0] op_b_i,
  input  logic [3:0]      dest_reg_i,
  input  logic            set_flags_i,
  input  status_register  status_reg_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [WORD-1:0] result_o,
  output logic [3:0]      dest_reg_o,
  output logic            flags_we_o,
  output status_register  status_reg_o
);

  localparam int STEPS = WORD / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(STEPS - 1);

  mult_state_t      state_q, state_d;
  logic [WORD-1:0]  acc_q, mcand_q, mplier_q;
  logic [CNT_W-1:0] count_q;
  logic [3:0]       dest_cap_q;
  logic             set_flags_q, c_q, v_q;
  logic [WORD-1:0]  result_q;
  logic [3:0]       dest_q;
  status_register   status_q;

  logic [WORD-1:0]  acc_s, mcand_s, mplier_s;
  logic             accept, run_exit, run_step;

  mult_radix_step #(
    .WORD           (WORD),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_s),
    .mcand_o  (mcand_s),
    .mplier_o (mplier_s)
  );

  assign accept   = ((state_q == IDLE) || (state_q == DONE)) && start_i && !flush_i;
  assign run_step = (state_q == RUN) && !flush_i;
  assign run_exit = (count_q == LAST_COUNT) || (EARLY_TERM && (mplier_s == '0));

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and status outputs of the FSM.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d        = state_q;
    stall_o        = accept;
    busy_o         = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        busy_o  = 1'b1;
        stall_o = 1'b1;
        if (flush_i)       state_d = IDLE;
        else if (run_exit) state_d = DONE;
      end
      DONE: begin
        // A flush in the completion cycle kills the pulse combinationally.
        result_valid_o = !flush_i;
        state_d        = accept ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign flags_we_o = result_valid_o && set_flags_q;

  // Operand capture on accept and per-cycle iteration while running.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: datapath registers are reset too, so outputs read zero during reset.
    if (!rst_n_i) begin
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      dest_cap_q  <= '0;
      set_flags_q <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else if (accept) begin
      acc_q       <= '0;
      mcand_q     <= op_a_i;
      mplier_q    <= op_b_i;
      count_q     <= '0;
      dest_cap_q  <= dest_reg_i;
      set_flags_q <= set_flags_i;
      c_q         <= status_reg_i.c;
      v_q         <= status_reg_i.v;
    end else if (run_step) begin
      acc_q    <= acc_s;
      mcand_q  <= mcand_s;
      mplier_q <= mplier_s;
      count_q  <= count_q + CNT_W'(1);
    end
  end

  // Result registers: written only on the final RUN cycle, held otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_q <= '0;
      dest_q   <= '0;
      status_q <= '0;
    end else if (run_step && run_exit) begin
      result_q   <= acc_s;
      dest_q     <= dest_cap_q;
      status_q.n <= acc_s[WORD-1];
      status_q.z <= (acc_s == '0);
      status_q.c <= c_q;
      status_q.v <= v_q;
    end
  end

  assign result_o     = result_q;
  assign dest_reg_o   = dest_q;
  assign status_reg_o = status_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench: three sequencer configurations share one stimulus
// stream; a cycle-level reference model (product by plain arithmetic, run
// length from the multiplier's bit width) is compared on every negedge.
module tb_alu_mult_sequencer;
  import GENERAL_DEFS::*;

  localparam int NI = 3;
  localparam int BPC_T [NI] = '{1, 1, 4};
  localparam bit ET_T  [NI] = '{1'b1, 1'b0, 1'b0};

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           flush = 1'b0;
  logic [31:0]    op_a = '0;
  logic [31:0]    op_b = '0;
  logic [3:0]     dest = '0;
  logic           sf = 1'b0;
  status_register st_in = '0;

  logic           stall [NI];
  logic           busy  [NI];
  logic           rv    [NI];
  logic           fwe   [NI];
  logic [31:0]    res   [NI];
  logic [3:0]     dst   [NI];
  status_register sto   [NI];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_mult_sequencer #(.BITS_PER_CYCLE(1), .EARLY_TERM(1'b1)) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .flush_i(flush), .op_a_i(op_a),
    .op_b_i(op_b), .dest_reg_i(dest), .set_flags_i(sf), .status_reg_i(st_in),
    .stall_o(stall[0]), .busy_o(busy[0]), .result_valid_o(rv[0]), .result_o(res[0]),
    .dest_reg_o(dst[0]), .flags_we_o(fwe[0]), .status_reg_o(sto[0]));

  alu_mult_sequencer #(.BITS_PER_CYCLE(1), .EARLY_TERM(1'b0)) u1 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .flush_i(flush), .op_a_i(op_a),
    .op_b_i(op_b), .dest_reg_i(dest), .set_flags_i(sf), .status_reg_i(st_in),
    .stall_o(stall[1]), .busy_o(busy[1]), .result_valid_o(rv[1]), .result_o(res[1]),
    .dest_reg_o(dst[1]), .flags_we_o(fwe[1]), .status_reg_o(sto[1]));

  alu_mult_sequencer #(.BITS_PER_CYCLE(4), .EARLY_TERM(1'b0)) u2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .flush_i(flush), .op_a_i(op_a),
    .op_b_i(op_b), .dest_reg_i(dest), .set_flags_i(sf), .status_reg_i(st_in),
    .stall_o(stall[2]), .busy_o(busy[2]), .result_valid_o(rv[2]), .result_o(res[2]),
    .dest_reg_o(dst[2]), .flags_we_o(fwe[2]), .status_reg_o(sto[2]));

  // ---------------- reference model ----------------
  int             run_left [NI] = '{0, 0, 0};
  bit             in_done  [NI] = '{0, 0, 0};
  int             acc_cnt  [NI] = '{0, 0, 0};
  logic [31:0]    p_res [NI] = '{default: '0};
  logic [3:0]     p_dest[NI] = '{default: '0};
  logic           p_sf  [NI] = '{default: 1'b0};
  logic           p_c   [NI] = '{default: 1'b0};
  logic           p_v   [NI] = '{default: 1'b0};
  logic [31:0]    e_res [NI] = '{default: '0};
  logic [3:0]     e_dest[NI] = '{default: '0};
  logic           e_sf  [NI] = '{default: 1'b0};
  status_register e_st  [NI] = '{default: '0};

  // Number of RUN cycles for multiplier b on configuration i.
  function automatic int calc_r(input int i, input logic [31:0] b);
    int msb = -1;
    if (!ET_T[i]) return 32 / BPC_T[i];
    for (int k = 0; k < 32; k++) if (b[k]) msb = k;
    if (msb < 0) return 1;
    return (msb + BPC_T[i]) / BPC_T[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        run_left[i] <= 0;
        in_done[i]  <= 1'b0;
        e_res[i]    <= '0;
        e_dest[i]   <= '0;
        e_sf[i]     <= 1'b0;
        e_st[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (flush) begin
          run_left[i] <= 0;
          in_done[i]  <= 1'b0;
        end else if (run_left[i] == 0 && start) begin
          run_left[i] <= calc_r(i, op_b);
          p_res[i]    <= op_a * op_b;
          p_dest[i]   <= dest;
          p_sf[i]     <= sf;
          p_c[i]      <= st_in.c;
          p_v[i]      <= st_in.v;
          in_done[i]  <= 1'b0;
          acc_cnt[i]  <= acc_cnt[i] + 1;
        end else if (run_left[i] > 0) begin
          run_left[i] <= run_left[i] - 1;
          if (run_left[i] == 1) begin
            in_done[i] <= 1'b1;
            e_res[i]   <= p_res[i];
            e_dest[i]  <= p_dest[i];
            e_sf[i]    <= p_sf[i];
            e_st[i]    <= '{n: p_res[i][31], z: (p_res[i] == 0), c: p_c[i], v: p_v[i]};
          end
        end else begin
          in_done[i] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d.stall", i), 32'(stall[i]),
            32'((run_left[i] > 0) || (start && !flush)));
      check($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(run_left[i] > 0));
      check($sformatf("u%0d.valid", i), 32'(rv[i]), 32'(in_done[i] && !flush));
      check($sformatf("u%0d.flags_we", i), 32'(fwe[i]), 32'(in_done[i] && !flush && e_sf[i]));
      check($sformatf("u%0d.result", i), res[i], e_res[i]);
      check($sformatf("u%0d.dest", i), 32'(dst[i]), 32'(e_dest[i]));
      check($sformatf("u%0d.status", i), 32'(sto[i]), 32'(e_st[i]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle, then scramble the operands and flip
  // C/V so later sampling would be visible.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] d,
                       input logic s, input logic c, input logic v);
    op_a  = a;
    op_b  = b;
    dest  = d;
    sf    = s;
    st_in = '{n: 1'b0, z: 1'b0, c: c, v: v};
    start = 1'b1;
    step();
    start   = 1'b0;
    op_a    = $urandom;
    op_b    = $urandom;
    st_in.c = ~c;
    st_in.v = ~v;
  endtask

  task automatic wait_valid(input int i, input int max, output int k);
    k = 0;
    for (int n = 1; n <= max; n++) begin
      @(negedge clk);
      if (rv[i]) begin
        k = n;
        return;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    int cyc;

    // Reset: outputs zero without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst.busy", 32'(busy[i]), 32'd0);
      check("rst.valid", 32'(rv[i]), 32'd0);
      check("rst.result", res[i], 32'd0);
      check("rst.status", 32'(sto[i]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 7*6, early termination: R=3, pulse at t+4.
    step();
    issue(32'd7, 32'd6 + 32'd0, 4'd3, 1'b1, 1'b1, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check("mul7x6.stall_run", 32'(stall[0]), 32'd1);
      check("mul7x6.no_early_valid", 32'(rv[0]), 32'd0);
    end
    @(negedge clk);
    check("mul7x6.valid_t4", 32'(rv[0]), 32'd1);
    check("mul7x6.result", res[0], 32'd42);
    check("mul7x6.nz", 32'({sto[0].n, sto[0].z}), 32'd0);
    check("mul7x6.cv", 32'({sto[0].c, sto[0].v}), 32'b10);
    check("mul7x6.flags_we", 32'(fwe[0]), 32'd1);
    check("mul7x6.dest", 32'(dst[0]), 32'd3);
    check("mul7x6.stall_done", 32'(stall[0]), 32'd0);
    repeat (40) step();

    // All-ones squared, full-length run: pulse at t+33, low word 1.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hA, 1'b1, 1'b1, 1'b1);
    wait_valid(1, 40, k);
    check("ones.latency", 32'(k), 32'd33);
    check("ones.result", res[1], 32'h0000_0001);
    check("ones.status", 32'(sto[1]), 32'b0011);
    check("ones.dest", 32'(dst[1]), 32'hA);
    repeat (10) step();

    // Single-cycle runs.
    issue(32'h8000_0000, 32'd1, 4'd1, 1'b1, 1'b0, 1'b0);
    wait_valid(0, 40, k);
    check("msb.latency", 32'(k), 32'd2);
    check("msb.result", res[0], 32'h8000_0000);
    check("msb.n", 32'(sto[0].n), 32'd1);
    step();
    issue(32'h1234, 32'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    wait_valid(0, 40, k);
    check("zero.latency", 32'(k), 32'd2);
    check("zero.result", res[0], 32'd0);
    check("zero.z", 32'(sto[0].z), 32'd1);

    // Overflowing product with flags disabled.
    step();
    issue(32'h0001_0000, 32'h0001_0000, 4'd4, 1'b0, 1'b0, 1'b0);
    wait_valid(0, 40, k);
    check("wrap.latency", 32'(k), 32'd18);
    check("wrap.result", res[0], 32'd0);
    check("wrap.flags_we", 32'(fwe[0]), 32'd0);
    check("wrap.z", 32'(sto[0].z), 32'd1);
    repeat (40) step();

    // Flush in the 5th RUN cycle, then a new request the next cycle.
    issue(32'd3, 32'hFFFF_FFFF, 4'd6, 1'b1, 1'b0, 1'b0);
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    op_a  = 32'd9;
    op_b  = 32'd11;
    dest  = 4'd5;
    sf    = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("flush.no_valid", 32'(rv[0]), 32'd0);
    check("flush.idle", 32'(busy[0]), 32'd0);
    check("flush.accept_stall", 32'(stall[0]), 32'd1);
    check("flush.result_held", res[0], 32'd0);
    step();
    start = 1'b0;
    wait_valid(0, 20, k);
    check("after_flush.latency", 32'(k), 32'd5);
    check("after_flush.result", res[0], 32'd99);
    repeat (40) step();

    // Back-to-back: second request accepted in the DONE cycle of the first.
    issue(32'd2, 32'd2, 4'd7, 1'b1, 1'b0, 1'b0);
    step();
    step();
    op_a  = 32'd3;
    op_b  = 32'd5;
    dest  = 4'd8;
    start = 1'b1;
    @(negedge clk);
    check("b2b.first_valid", 32'(rv[0]), 32'd1);
    check("b2b.first_result", res[0], 32'd4);
    step();
    start = 1'b0;
    wait_valid(0, 10, k);
    check("b2b.second_latency", 32'(k), 32'd4);
    check("b2b.second_result", res[0], 32'd15);
    repeat (40) step();

    // Asynchronous reset in the middle of a run.
    issue(32'd5, 32'hFFFF_FFFF, 4'd9, 1'b1, 1'b1, 1'b1);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("arst.stall", 32'(stall[i]), 32'd0);
      check("arst.busy", 32'(busy[i]), 32'd0);
      check("arst.result", res[i], 32'd0);
      check("arst.dest", 32'(dst[i]), 32'd0);
      check("arst.status", 32'(sto[i]), 32'd0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("arst.idle_after", 32'(busy[0]), 32'd0);

    // Randomized traffic until the 4-bit configuration has seen 1000 requests.
    base = acc_cnt[2];
    cyc  = 0;
    while ((acc_cnt[2] - base) < 1000 && cyc < 40000) begin
      step();
      cyc++;
      start = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      op_a  = $urandom;
      op_b  = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      dest  = 4'($urandom_range(0, 15));
      sf    = 1'($urandom_range(0, 1));
      st_in = status_register'($urandom_range(0, 15));
    end
    check("rand.budget", 32'(cyc < 40000), 32'd1);
    start = 1'b0;
    flush = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
